dmem_arbiter: RTL and testbench

Two-port arbiter that shares the DLX single-port data memory between the CPU load/store stage and a debug/testbench port used for preloading data and checking memory contents. It sits between the datapath memory stage and the data RAM. The CPU has fixed priority. A wait counter guarantees the debug port a grant after at most MAX_WAIT stalled cycles. Read responses come back one cycle after the grant and go only to the port that issued the read.

---
 rtl/dmem_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU memory
// stage (fixed priority) and a debug port. The debug port is promoted
// once it has been stalled MAX_WAIT cycles. Read data returns one cycle
// after the grant and is steered only to the requesting port.
module dmem_arbiter #(
  parameter int WORD     = 32,
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4,
  localparam int WAIT_W  = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD-1:0]   cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [WORD-1:0]   cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [WORD-1:0]   dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [WORD-1:0]   dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD-1:0]   mem_wdata,
  input  logic [WORD-1:0]   mem_rdata,
  output logic [WAIT_W-1:0] dbg_wait
);

  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              rd_cpu_reg, rd_cpu_next;
  logic              rd_dbg_reg, rd_dbg_next;
  logic              sel_cpu, sel_dbg;

  // Arbitration: debug wins when the CPU is idle or debug has waited long
  // enough; nothing is granted while reset is held.
  always_comb begin
    sel_dbg = rst & dbg_req & (~cpu_req | (wait_reg == WAIT_SAT));
    sel_cpu = rst & cpu_req & ~sel_dbg;
  end

  assign cpu_gnt = sel_cpu;
  assign dbg_gnt = sel_dbg;

  // RAM drive comes straight from the winner; idle bus is all zeros.
  always_comb begin
    mem_en    = sel_cpu | sel_dbg;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sel_dbg) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (sel_cpu) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Next state: the wait count restarts whenever debug is served or stops
  // asking, otherwise climbs to saturation; read tags follow granted reads.
  always_comb begin
    wait_next   = wait_reg;
    rd_cpu_next = sel_cpu & ~cpu_we;
    rd_dbg_next = sel_dbg & ~dbg_we;
    if (sel_dbg || !dbg_req) begin
      wait_next = '0;
    end else if (wait_reg != WAIT_SAT) begin
      wait_next = wait_reg + WAIT_W'(1);
    end
  end

  // State registers; a reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_reg   <= '0;
      rd_cpu_reg <= 1'b0;
      rd_dbg_reg <= 1'b0;
    end else begin
      wait_reg   <= wait_next;
      rd_cpu_reg <= rd_cpu_next;
      rd_dbg_reg <= rd_dbg_next;
    end
  end

  // Status outputs are held at zero for the whole reset interval.
  assign cpu_rvalid = rd_cpu_reg & rst;
  assign dbg_rvalid = rd_dbg_reg & rst;
  assign dbg_wait   = rst ? wait_reg : '0;

  // Read data is masked per bit so a port only sees its own response.
  generate
    for (genvar gi = 0; gi < WORD; gi++) begin : g_rdata
      assign cpu_rdata[gi] = mem_rdata[gi] & cpu_rvalid;
      assign dbg_rdata[gi] = mem_rdata[gi] & dbg_rvalid;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a behavioural single-port RAM sits behind the
// arbiter; read expectations are queued at grant time and popped when the
// response cycle is reached.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [9:0]  cpu_addr, dbg_addr, mem_addr;
  logic [31:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic        mem_en, mem_we;
  logic [2:0]  dbg_wait;

  typedef struct packed {
    logic        is_dbg;
    logic [31:0] data;
  } resp_t;

  resp_t       sb_q[$];
  resp_t       exp;
  logic [31:0] exp_mem [int];
  logic [31:0] ram [1024];
  logic [31:0] ram_q;
  int          tests_run = 0;
  int          tests_failed = 0;

  dmem_arbiter #(.WORD(32), .ADDR_W(10), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_wait(dbg_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with registered read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h10; cpu_wdata = '0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h20; dbg_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if ({cpu_gnt, dbg_gnt, mem_en, cpu_rvalid, dbg_rvalid} !== 5'b0 || dbg_wait !== 3'd0) begin
        tests_failed++;
        $display("FAIL reset_outputs: gnt=%b%b en=%b rvalid=%b%b wait=%0d, required all 0",
                 cpu_gnt, dbg_gnt, mem_en, cpu_rvalid, dbg_rvalid, dbg_wait);
      end
      tick();
    end
    rst = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0;
    tick();
  endtask

  task automatic test_dbg_write(input logic [9:0] addr, input logic [31:0] data);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = addr; dbg_wdata = data;
    @(negedge clk);
    tests_run++;
    if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
        mem_addr !== addr || mem_wdata !== data) begin
      tests_failed++;
      $display("FAIL dbg_write_grant: gnt=%b/%b en=%b we=%b addr=%h wdata=%h, required 0/1 1 1 %h %h",
               cpu_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata, addr, data);
    end
    exp_mem[int'(addr)] = data;
    tick();
    dbg_req = 1'b0; dbg_we = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL dbg_write_no_rvalid: rvalid=%b/%b, required 0/0", cpu_rvalid, dbg_rvalid);
    end
    tick();
  endtask

  task automatic test_cpu_read(input logic [9:0] addr);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
    @(negedge clk);
    tests_run++;
    if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== addr) begin
      tests_failed++;
      $display("FAIL cpu_read_grant: gnt=%b/%b en=%b we=%b addr=%h, required 1/0 1 0 %h",
               cpu_gnt, dbg_gnt, mem_en, mem_we, mem_addr, addr);
    end
    sb_q.push_back('{is_dbg: 1'b0, data: exp_mem[int'(addr)]});
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    exp = sb_q.pop_front();
    tests_run++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp.data || dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL cpu_read_resp: cpu %b/%h dbg %b/%h, required cpu 1/%h dbg 0/0",
               cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata, exp.data);
    end
    tick();
  endtask

  task automatic test_starvation();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h20; cpu_wdata = 32'hA5A5_A5A5;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (i < 4) begin
        if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || dbg_wait !== 3'(i)) begin
          tests_failed++;
          $display("FAIL starve_wait c%0d: gnt=%b/%b wait=%0d, required 1/0 wait=%0d",
                   i, cpu_gnt, dbg_gnt, dbg_wait, i);
        end
      end else begin
        if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b1 || dbg_wait !== 3'd4 || mem_addr !== 10'h10) begin
          tests_failed++;
          $display("FAIL starve_promote: gnt=%b/%b wait=%0d addr=%h, required 0/1 wait=4 addr=010",
                   cpu_gnt, dbg_gnt, dbg_wait, mem_addr);
        end
        sb_q.push_back('{is_dbg: 1'b1, data: exp_mem[32'h10]});
      end
      tick();
    end
    exp_mem[32'h20] = 32'hA5A5_A5A5;
    dbg_req = 1'b0;
    @(negedge clk);
    exp = sb_q.pop_front();
    tests_run++;
    if (dbg_wait !== 3'd0 || cpu_gnt !== 1'b1 || dbg_rvalid !== 1'b1 || dbg_rdata !== exp.data ||
        cpu_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL starve_after: wait=%0d cpu_gnt=%b dbg %b/%h cpu_rvalid=%b, required 0 1 1/%h 0",
               dbg_wait, cpu_gnt, dbg_rvalid, dbg_rdata, cpu_rvalid, exp.data);
    end
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
  endtask

  task automatic test_interleaved();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF;
    @(negedge clk);
    tests_run++;
    if (cpu_gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL inter_cpu_gnt: cpu_gnt=%b, required 1", cpu_gnt);
    end
    sb_q.push_back('{is_dbg: 1'b0, data: exp_mem[32'h3FF]});
    tick();
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h20;
    @(negedge clk);
    exp = sb_q.pop_front();
    tests_run++;
    if (dbg_gnt !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== exp.data || dbg_rvalid !== 1'b0 ||
        dbg_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL inter_cpu_resp: dbg_gnt=%b cpu %b/%h dbg %b/%h, required 1 1/%h 0/0",
               dbg_gnt, cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata, exp.data);
    end
    sb_q.push_back('{is_dbg: 1'b1, data: exp_mem[32'h20]});
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
    exp = sb_q.pop_front();
    tests_run++;
    if (dbg_rvalid !== 1'b1 || dbg_rdata !== exp.data || cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL inter_dbg_resp: dbg %b/%h cpu %b/%h, required 1/%h 0/0",
               dbg_rvalid, dbg_rdata, cpu_rvalid, cpu_rdata, exp.data);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h21; cpu_wdata = 32'h0BAD_F00D;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h10;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) dbg_req = 1'b0;
      if (c == 3) dbg_req = 1'b1;
      if (c == 4) cpu_req = 1'b0;
      if (c == 5) dbg_req = 1'b0;
      @(negedge clk);
      tests_run++;
      case (c)
        0, 1: if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || dbg_wait !== 3'(c)) begin
          tests_failed++;
          $display("FAIL simul_c%0d: gnt=%b/%b wait=%0d, required 1/0 wait=%0d", c, cpu_gnt, dbg_gnt, dbg_wait, c);
        end
        2: if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || dbg_wait !== 3'd2) begin
          tests_failed++;
          $display("FAIL simul_drop: gnt=%b/%b wait=%0d, required 1/0 wait=2", cpu_gnt, dbg_gnt, dbg_wait);
        end
        3: if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || dbg_wait !== 3'd0) begin
          tests_failed++;
          $display("FAIL simul_cleared: gnt=%b/%b wait=%0d, required 1/0 wait=0", cpu_gnt, dbg_gnt, dbg_wait);
        end
        4: begin
          if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b1 || mem_addr !== 10'h10) begin
            tests_failed++;
            $display("FAIL simul_dbg_alone: gnt=%b/%b addr=%h, required 0/1 010", cpu_gnt, dbg_gnt, mem_addr);
          end
          sb_q.push_back('{is_dbg: 1'b1, data: exp_mem[32'h10]});
        end
        default: begin
          exp = sb_q.pop_front();
          if (dbg_rvalid !== 1'b1 || dbg_rdata !== exp.data || cpu_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_resp: dbg %b/%h cpu_rvalid=%b, required 1/%h 0",
                     dbg_rvalid, dbg_rdata, cpu_rvalid, exp.data);
          end
        end
      endcase
      tick();
    end
    exp_mem[32'h21] = 32'h0BAD_F00D;
    cpu_we = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'(10'h40 + i); dbg_wdata = d;
      @(negedge clk);
      tests_run++;
      if (dbg_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== d) begin
        tests_failed++;
        $display("FAIL b2b_write%0d: gnt=%b we=%b wdata=%h, required 1 1 %h", i, dbg_gnt, mem_we, mem_wdata, d);
      end
      exp_mem[32'h40 + i] = d;
      tick();
    end
    dbg_req = 1'b0; dbg_we = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      cpu_req = (i < 6); cpu_we = 1'b0; cpu_addr = 10'(10'h45 - i);
      @(negedge clk);
      if (i > 0) begin
        exp = sb_q.pop_front();
        tests_run++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp.data || dbg_rvalid !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_resp%0d: cpu %b/%h dbg_rvalid=%b, required 1/%h 0",
                   i - 1, cpu_rvalid, cpu_rdata, dbg_rvalid, exp.data);
        end
      end
      if (i < 6) begin
        tests_run++;
        if (cpu_gnt !== 1'b1 || mem_addr !== cpu_addr) begin
          tests_failed++;
          $display("FAIL b2b_gnt%0d: gnt=%b addr=%h, required 1 %h", i, cpu_gnt, mem_addr, cpu_addr);
        end
        sb_q.push_back('{is_dbg: 1'b0, data: exp_mem[32'h45 - i]});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h10;
    @(negedge clk);
    tests_run++;
    if (cpu_gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_gnt: cpu_gnt=%b, required 1", cpu_gnt);
    end
    #2 rst = 1'b0;
    tick();
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0 || dbg_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_drop: cpu %b/%h dbg_rvalid=%b, required 0/0 0", cpu_rvalid, cpu_rdata, dbg_rvalid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_dbg_write(10'h10, 32'hDEAD_BEEF);
    test_cpu_read(10'h10);
    test_dbg_write(10'h3FF, 32'h1234_5678);
    test_cpu_read(10'h3FF);
    test_starvation();
    test_interleaved();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_read();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
